// File: rtl/tl_phase_timer_if.sv
// Signal bundle between the traffic-light FSM and the phase timer.
// master = light-controller side, slave = timer side.
interface tl_phase_timer_if #(
  parameter int unsigned CNT_W = 8
);
  logic             tick;
  logic             timer_select;
  logic             ped_req;
  logic             hold;
  logic             done_pulse;
  logic             ped_ack;
  logic [CNT_W-1:0] remaining;
  logic             ped_pending;

  modport master (
    output tick, timer_select, ped_req, hold,
    input  done_pulse, ped_ack, remaining, ped_pending
  );

  modport slave (
    input  tick, timer_select, ped_req, hold,
    output done_pulse, ped_ack, remaining, ped_pending
  );
endinterface

// File: rtl/tl_phase_timer.sv
// Phase-duration sequencer: times green/yellow phases in tick units, strobes
// done_pulse on expiry and truncates green for a pending pedestrian request.
module tl_phase_timer #(
  parameter int unsigned GREEN_TICKS     = 30,
  parameter int unsigned YELLOW_TICKS    = 4,
  parameter int unsigned MIN_GREEN_TICKS = 8,
  parameter int unsigned CNT_W           = 8
) (
  input logic           clk,
  input logic           rst,
  tl_phase_timer_if.slave bus
);

  typedef enum logic [1:0] {LOAD, RUN, FIRE} state_t;

  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] MIN_EL    = CNT_W'(MIN_GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] elapsed, elapsed_nx;
  logic             sel_q, sel_nx;
  logic             ped_pend, ped_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= LOAD;
      cnt      <= '0;
      elapsed  <= '0;
      sel_q    <= 1'b0;
      ped_pend <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      elapsed  <= elapsed_nx;
      sel_q    <= sel_nx;
      ped_pend <= ped_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    elapsed_nx = elapsed;
    sel_nx     = sel_q;
    ped_nx     = ped_pend;
    case (state)
      LOAD: begin
        sel_nx     = bus.timer_select;
        cnt_nx     = bus.timer_select ? GREEN_LD : YELLOW_LD;
        elapsed_nx = '0;
        state_nx   = RUN;
      end
      RUN: begin
        if (bus.tick && !bus.hold) begin
          if (cnt == '0 || (sel_q && ped_pend && elapsed >= MIN_EL)) begin
            state_nx = FIRE;
          end else begin
            cnt_nx = cnt - ONE;
            if (elapsed != '1) elapsed_nx = elapsed + ONE;
          end
        end
      end
      FIRE: begin
        state_nx = LOAD;
        if (sel_q) ped_nx = 1'b0;
      end
      default: state_nx = LOAD;
    endcase
    // A new request in the FIRE cycle overrides the serve-clear above.
    if (bus.ped_req) ped_nx = 1'b1;
  end

  assign bus.done_pulse  = (state == FIRE);
  assign bus.ped_ack     = (state == FIRE) && sel_q && ped_pend;
  assign bus.remaining   = cnt;
  assign bus.ped_pending = ped_pend;

endmodule

// File: tb/tb_tl_phase_timer.sv
// Scoreboard bench for tl_phase_timer: stimulus queues expected done/ack
// strobes, an independent monitor compares them as the DUT emits them.
module tb_tl_phase_timer;

  localparam int unsigned CNT_W = 8;

  typedef struct {
    int unsigned cyc;
    bit          ack;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  exp_t        sb[$];
  exp_t        e;

  tl_phase_timer_if #(.CNT_W(CNT_W)) bus ();

  tl_phase_timer #(
    .GREEN_TICKS    (5),
    .YELLOW_TICKS   (2),
    .MIN_GREEN_TICKS(3),
    .CNT_W          (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() > 0 && cyc > sb[0].cyc) begin
        e = sb.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missing_done: no done_pulse at cycle %0d, required one", e.cyc);
      end
      if (bus.done_pulse) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: done_pulse=1 at cycle %0d, required 0", cyc);
        end else begin
          e = sb.pop_front();
          n_cmp++;
          if (cyc != e.cyc || bus.ped_ack != e.ack) begin
            n_bad++;
            $display("FAIL done_event: got cycle %0d ack %0b, required cycle %0d ack %0b",
                     cyc, bus.ped_ack, e.cyc, e.ack);
          end
        end
      end else if (bus.ped_ack) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stray_ack: ped_ack=1 without done_pulse at cycle %0d", cyc);
      end
    end
  end

  task automatic check(input string name, input int unsigned got, input int unsigned req);
    n_cmp++;
    if (got != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // One tick; if it should expire the phase, queue the expected strobe and
  // let the model light FSM flip timer_select during the FIRE cycle.
  task automatic tick_once(input bit exp_fire, input bit exp_ack, input bit collide);
    @(negedge clk);
    if (exp_fire) sb.push_back('{cyc + 1, exp_ack});
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    if (exp_fire) begin
      bus.timer_select = ~bus.timer_select;
      if (collide) bus.ped_req = 1'b1;
    end
    @(negedge clk);
    bus.ped_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic phase(input int unsigned n, input bit ack);
    for (int unsigned i = 1; i <= n; i++) tick_once(i == n, ack, 1'b0);
  endtask

  task automatic ped_pulse();
    @(negedge clk);
    bus.ped_req = 1'b1;
    @(negedge clk);
    bus.ped_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tick = 1'b0;
    bus.timer_select = 1'b1;
    bus.ped_req = 1'b0;
    bus.hold = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_done", bus.done_pulse, 0);
    check("rst_ack", bus.ped_ack, 0);
    check("rst_remaining", bus.remaining, 0);
    check("rst_pending", bus.ped_pending, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Green/yellow cycling.
    tick_once(1'b0, 1'b0, 1'b0);
    check("green_rem_t1", bus.remaining, 3);
    phase(4, 1'b0);
    phase(2, 1'b0);
    phase(5, 1'b0);
    phase(2, 1'b0);

    // Pedestrian truncation at the 3rd green tick.
    ped_pulse();
    check("trunc_pending_set", bus.ped_pending, 1);
    phase(3, 1'b1);
    check("trunc_pending_clr", bus.ped_pending, 0);

    // Request during yellow carries into the next green.
    ped_pulse();
    phase(2, 1'b0);
    check("yellow_pending_kept", bus.ped_pending, 1);
    phase(3, 1'b1);
    phase(2, 1'b0);

    // Hold over ticks 2-4 of a 5-tick green.
    tick_once(1'b0, 1'b0, 1'b0);
    check("hold_rem_t1", bus.remaining, 3);
    bus.hold = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      tick_once(1'b0, 1'b0, 1'b0);
      check("hold_rem_frozen", bus.remaining, 3);
    end
    bus.hold = 1'b0;
    phase(4, 1'b0);
    phase(2, 1'b0);

    // Hold on the expiring tick loses it.
    for (int unsigned i = 0; i < 4; i++) tick_once(1'b0, 1'b0, 1'b0);
    bus.hold = 1'b1;
    tick_once(1'b0, 1'b0, 1'b0);
    bus.hold = 1'b0;
    check("hold_final_rem", bus.remaining, 0);
    tick_once(1'b1, 1'b0, 1'b0);
    phase(2, 1'b0);

    // Request in the FIRE cycle of a served green stays pending.
    ped_pulse();
    tick_once(1'b0, 1'b0, 1'b0);
    tick_once(1'b0, 1'b0, 1'b0);
    tick_once(1'b1, 1'b1, 1'b1);
    check("collide_pending", bus.ped_pending, 1);
    phase(2, 1'b0);
    phase(3, 1'b1);
    phase(2, 1'b0);

    // Reset mid-phase discards the phase and the pending request.
    tick_once(1'b0, 1'b0, 1'b0);
    tick_once(1'b0, 1'b0, 1'b0);
    check("mid_rem", bus.remaining, 2);
    ped_pulse();
    check("mid_pending", bus.ped_pending, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_done", bus.done_pulse, 0);
    check("mid_rst_ack", bus.ped_ack, 0);
    check("mid_rst_rem", bus.remaining, 0);
    check("mid_rst_pending", bus.ped_pending, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    phase(5, 1'b0);

    repeat (6) @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL leftover_expect: cycle %0d ack %0b never observed", e.cyc, e.ack);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
